fft_col_collector: RTL and testbench

FFT_COL_COLLECTOR -- requirements
Module: fft_col_collector

---
 rtl/fft_col_collector.sv | 108 ++++++++++
 tb/tb_fft_col_collector.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fft_col_collector.sv
// Collects four butterfly beats (mux phases 0..3) into ping-pong frame banks.
// Optional `FFT_COL_HALVE_EN: halve every stored real/imag single on write.
module fft_col_collector #(
    parameter int NMAC = 4,
    parameter int CW   = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [1:0]             in_sel,
    input  logic [2*NMAC*CW-1:0]   in_data,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [8*NMAC*CW-1:0]   out_data,
    input  logic                   out_ready,
    output logic                   seq_err
);

    localparam int FW = 8*NMAC*CW;
    localparam int IW = 2*NMAC*CW;

    logic [FW-1:0] bank [2];
    logic [1:0]    full;
    logic [1:0]    full_next;
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    phase;
    logic          accept;
    logic          phase_ok;
    logic          release_fire;
    logic          frame_done;
    logic [IW-1:0] beat_data;

`ifdef FFT_COL_HALVE_EN
    // Exponent 0/1 flush to signed zero rather than producing a subnormal.
    function automatic logic [31:0] halve(input logic [31:0] f);
        if (f[30:23] == 8'hff)
            return f;
        else if (f[30:23] <= 8'd1)
            return {f[31], 31'b0};
        else
            return {f[31], f[30:23] - 8'd1, f[22:0]};
    endfunction

    always_comb begin
        beat_data = in_data;
        for (int unsigned j = 0; j < 2*NMAC; j++) begin
            beat_data[CW*j+CW-32 +: 32] = halve(in_data[CW*j+CW-32 +: 32]);
            beat_data[CW*j +: 32]       = halve(in_data[CW*j +: 32]);
        end
    end
`else
    assign beat_data = in_data;
`endif

    always_comb begin
        in_ready     = !full[wr_ptr];
        out_valid    = full[rd_ptr];
        out_data     = out_valid ? bank[rd_ptr] : '0;
        accept       = in_valid && in_ready && !reset;
        phase_ok     = (in_sel == phase);
        release_fire = out_valid && out_ready;
        frame_done   = accept && phase_ok && (phase == 2'd3);
    end

    // Release and completion always target different banks, so both apply.
    always_comb begin
        full_next = full;
        if (release_fire)
            full_next[rd_ptr] = 1'b0;
        if (frame_done)
            full_next[wr_ptr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full    <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            phase   <= '0;
            seq_err <= 1'b0;
        end else begin
            full    <= full_next;
            seq_err <= accept && !phase_ok;
            if (release_fire)
                rd_ptr <= ~rd_ptr;
            if (accept) begin
                if (!phase_ok) begin
                    phase <= '0;
                end else begin
                    phase <= phase + 2'd1;
                    if (phase == 2'd3)
                        wr_ptr <= ~wr_ptr;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && phase_ok) begin
            for (int unsigned k = 0; k < NMAC; k++) begin
                bank[wr_ptr][CW*(8*k+32'(in_sel)) +: CW]   <= beat_data[CW*(2*k) +: CW];
                bank[wr_ptr][CW*(8*k+4+32'(in_sel)) +: CW] <= beat_data[CW*(2*k+1) +: CW];
            end
        end
    end

endmodule

// File: tb/tb_fft_col_collector.sv
// Self-checking bench for fft_col_collector: directed scenarios plus random
// traffic against a queue-of-frames reference model.
module tb_fft_col_collector;

    localparam int NMAC = 4;
    localparam int CW   = 64;
    localparam int IW   = 2*NMAC*CW;
    localparam int FW   = 8*NMAC*CW;
    localparam int NS   = 8*NMAC;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [1:0]    in_sel;
    logic [IW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [FW-1:0] out_data;
    logic          out_ready;
    logic          seq_err;

    always #5 clk = ~clk;

    fft_col_collector #(.NMAC(NMAC), .CW(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .seq_err   (seq_err)
    );

    int unsigned   n_checks = 0;
    int unsigned   n_pass   = 0;
    logic [FW-1:0] mq [$];
    logic [FW-1:0] partial = '0;
    int            exp_ph  = 0;
    bit            exp_err = 1'b0;

    function automatic logic [31:0] ref_halve(input logic [31:0] f);
        logic [7:0] e;
        e = f[30:23];
        if (e == 8'd255) return f;
        if (e <= 8'd1)   return {f[31], 31'b0};
        return {f[31], 8'(e - 8'd1), f[22:0]};
    endfunction

    function automatic logic [CW-1:0] ref_store(input logic [CW-1:0] w);
`ifdef FFT_COL_HALVE_EN
        return {ref_halve(w[63:32]), ref_halve(w[31:0])};
`else
        return w;
`endif
    endfunction

    function automatic logic [IW-1:0] rnd_beat();
        logic [IW-1:0] d;
        for (int i = 0; i < IW/32; i++) d[32*i +: 32] = $urandom;
        return d;
    endfunction

    task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    // One clock: drive inputs, advance the model across the edge, check at negedge.
    task automatic step(input bit rst, input bit v, input logic [1:0] sel,
                        input logic [IW-1:0] d, input bit ordy);
        bit            rdy_m;
        bit            acc;
        bit            rel;
        logic [FW-1:0] front;
        reset = rst; in_valid = v; in_sel = sel; in_data = d; out_ready = ordy;
        rdy_m = (mq.size() < 2);
        acc   = v && rdy_m && !rst;
        rel   = (mq.size() > 0) && ordy && !rst;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            exp_ph  = 0;
            exp_err = 1'b0;
        end else begin
            if (rel) void'(mq.pop_front());
            exp_err = 1'b0;
            if (acc) begin
                if (int'(sel) != exp_ph) begin
                    exp_err = 1'b1;
                    exp_ph  = 0;
                end else begin
                    for (int k = 0; k < NMAC; k++) begin
                        partial[CW*(8*k+exp_ph) +: CW]   = ref_store(d[CW*(2*k) +: CW]);
                        partial[CW*(8*k+4+exp_ph) +: CW] = ref_store(d[CW*(2*k+1) +: CW]);
                    end
                    if (exp_ph == 3) begin
                        mq.push_back(partial);
                        exp_ph = 0;
                    end else begin
                        exp_ph++;
                    end
                end
            end
        end
        @(negedge clk);
        front = (mq.size() > 0) ? mq[0] : '0;
        chk("in_ready",  CW'(in_ready),  CW'(mq.size() < 2));
        chk("out_valid", CW'(out_valid), CW'(mq.size() > 0));
        chk("seq_err",   CW'(seq_err),   CW'(exp_err));
        for (int i = 0; i < NS; i++)
            chk($sformatf("out_slot%0d", i), out_data[CW*i +: CW], front[CW*i +: CW]);
    endtask

    task automatic idle(input bit ordy, input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'd0, '0, ordy);
    endtask

    initial begin
        logic [IW-1:0] d;
        logic [2:0]    sels [7];
        reset = 1'b1; in_valid = 1'b0; in_sel = '0; in_data = '0; out_ready = 1'b0;
        @(negedge clk);

        // Reset with in_valid asserted must be ignored.
        step(1'b1, 1'b1, 2'd0, rnd_beat(), 1'b0);
        step(1'b1, 1'b0, 2'd0, '0, 1'b0);
        idle(1'b0, 1);

        // Patterned frame, consumer ready.
        for (int s = 0; s < 4; s++) begin
            for (int j = 0; j < 2*NMAC; j++) d[CW*j +: CW] = {16'h0, 16'(s), 32'(j)};
            step(1'b0, 1'b1, 2'(s), d, 1'b1);
        end
        idle(1'b1, 2);

        // Backpressure: two frames fill both banks, ninth beat refused.
        for (int b = 0; b < 8; b++) step(1'b0, 1'b1, 2'(b % 4), rnd_beat(), 1'b0);
        for (int b = 0; b < 3; b++) step(1'b0, 1'b1, 2'd0, rnd_beat(), 1'b0);
        idle(1'b1, 3);

        // Phase-order violation then a clean frame.
        sels = '{3'd0, 3'd1, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3};
        for (int b = 0; b < 7; b++) step(1'b0, 1'b1, sels[b][1:0], rnd_beat(), 1'b1);
        idle(1'b1, 2);

        // Three back-to-back frames.
        for (int b = 0; b < 12; b++) step(1'b0, 1'b1, 2'(b % 4), rnd_beat(), 1'b1);
        idle(1'b1, 2);

        // Reset mid-frame, then reset with an unread full bank.
        for (int b = 0; b < 2; b++) step(1'b0, 1'b1, 2'(b), rnd_beat(), 1'b1);
        step(1'b1, 1'b0, 2'd0, '0, 1'b1);
        for (int b = 0; b < 5; b++) step(1'b0, 1'b1, 2'(b % 4), rnd_beat(), 1'b0);
        step(1'b1, 1'b1, 2'd1, rnd_beat(), 1'b0);
        idle(1'b0, 1);
        for (int b = 0; b < 4; b++) step(1'b0, 1'b1, 2'(b), rnd_beat(), 1'b1);
        idle(1'b1, 2);

        // Random traffic with occasional wrong phases and stalls.
        for (int c = 0; c < 150; c++) begin
            logic [1:0] sel;
            sel = ($urandom_range(7) == 0) ? 2'($urandom_range(3)) : 2'(exp_ph);
            step(1'b0, $urandom_range(3) != 0, sel, rnd_beat(), $urandom_range(2) != 0);
        end
        idle(1'b1, 3);

`ifdef FFT_COL_HALVE_EN
        d = rnd_beat();
        d[0 +: CW]  = 64'h3f800000_bf800000;
        d[CW +: CW] = 64'h00800000_7f800000;
        step(1'b0, 1'b1, 2'd0, d, 1'b0);
        for (int s = 1; s < 4; s++) step(1'b0, 1'b1, 2'(s), rnd_beat(), 1'b0);
        chk("halve_one",  out_data[0 +: CW],    64'h3f000000_bf000000);
        chk("halve_edge", out_data[CW*4 +: CW], 64'h00000000_7f800000);
        idle(1'b1, 2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
